// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg
// Shared definitions for the register-file sequencer: opcode constants,
// FSM state encoding, micro-instruction field positions and the
// "no write / DIN" register select.
package regfile_seq_pkg;

    // Micro-instruction opcodes. Values above OP_SHR are undefined.
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    // Micro-instruction layout: [15:12] opcode, [11:9] dst,
    // [8:6] srcA, [5:3] srcB, [2:0] reserved.
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int DST_HI  = 11;
    localparam int DST_LO  = 9;
    localparam int SRCA_HI = 8;
    localparam int SRCA_LO = 6;
    localparam int SRCB_HI = 5;
    localparam int SRCB_LO = 3;

    // Select 0 means "no write" on DSEL and "external DIN" on ASEL.
    localparam logic [2:0] REG_ZERO = 3'd0;

    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_SHR;
    endfunction

endpackage

// File: rtl/regfile_sequencer_if.sv
// regfile_sequencer_if
// Bundles the micro-instruction handshake and the register-file bus.
//   master : sequencer view (accepts INSTR, drives ASEL/BSEL/DSEL/RIN)
//   slave  : environment view (instruction source + register file)
// Handshake: a transfer happens on a rising edge where INSTR_VALID and
// INSTR_READY are both high; INSTR is only sampled on that edge.
// FLAGS exists only when REGFILE_SEQUENCER_FLAGS_EN is defined.
interface regfile_sequencer_if;
    logic [15:0] INSTR;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [2:0]  ASEL;
    logic [2:0]  BSEL;
    logic [15:0] ABUS;
    logic [15:0] BBUS;
    logic [2:0]  DSEL;
    logic [15:0] RIN;
    logic        DONE;
    logic        ILLEGAL;
`ifdef REGFILE_SEQUENCER_FLAGS_EN
    logic [2:0]  FLAGS;

    modport master (
        input  INSTR, INSTR_VALID, ABUS, BBUS,
        output INSTR_READY, ASEL, BSEL, DSEL, RIN, DONE, ILLEGAL, FLAGS
    );
    modport slave (
        output INSTR, INSTR_VALID, ABUS, BBUS,
        input  INSTR_READY, ASEL, BSEL, DSEL, RIN, DONE, ILLEGAL, FLAGS
    );
`else
    modport master (
        input  INSTR, INSTR_VALID, ABUS, BBUS,
        output INSTR_READY, ASEL, BSEL, DSEL, RIN, DONE, ILLEGAL
    );
    modport slave (
        output INSTR, INSTR_VALID, ABUS, BBUS,
        input  INSTR_READY, ASEL, BSEL, DSEL, RIN, DONE, ILLEGAL
    );
`endif
endinterface

// File: rtl/regfile_seq_alu.sv
// regfile_seq_alu
// Combinational ALU for the register-file sequencer.
//   opcode     in  4   micro-instruction opcode
//   a, b       in  16  operands
//   result     out 16  result (0 for NOP and undefined opcodes)
//   carry      out 1   ADD carry-out, SUB borrow, SHL/SHR shifted-out bit
//   writes_reg out 1   opcode produces a register write (MOV..SHR)
module regfile_seq_alu
    import regfile_seq_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output logic        carry,
    output logic        writes_reg
);

    logic [16:0] sum17;

    always_comb begin
        sum17      = {1'b0, a} + {1'b0, b};
        result     = 16'd0;
        carry      = 1'b0;
        writes_reg = 1'b1;
        case (opcode)
            OP_MOV: result = a;
            OP_ADD: begin
                result = sum17[15:0];
                carry  = sum17[16];
            end
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[14:0], 1'b0};
                carry  = a[15];
            end
            OP_SHR: begin
                result = {1'b0, a[15:1]};
                carry  = a[0];
            end
            default: writes_reg = 1'b0;   // NOP and undefined opcodes
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer
// Operand-fetch / writeback sequencer for an 8 x 16-bit register file.
// One micro-instruction per 4 cycles: IDLE -> READ -> EXEC -> WRITE.
//   CLK       in   clock, rising edge
//   RST       in   synchronous active-low reset
//   bus       if   regfile_sequencer_if.master (handshake + regfile bus)
//   state_dbg out  current FSM state
// Optional feature: REGFILE_SEQUENCER_FLAGS_EN adds the {N,C,Z} FLAGS output.
module regfile_sequencer
    import regfile_seq_pkg::*;
(
    input  logic                       CLK,
    input  logic                       RST,
    regfile_sequencer_if.master        bus,
    output state_e                     state_dbg
);

    state_e      state_q,   state_d;
    logic [3:0]  opcode_q,  opcode_d;
    logic [2:0]  dst_q,     dst_d;
    logic [15:0] opa_q,     opa_d;
    logic [15:0] opb_q,     opb_d;
    logic        ready_q,   ready_d;
    // ASEL/BSEL registers double as the latched srcA/srcB fields; they
    // are only needed during READ and must read 0 everywhere else.
    logic [2:0]  asel_q,    asel_d;
    logic [2:0]  bsel_q,    bsel_d;
    logic [2:0]  dsel_q,    dsel_d;
    logic [15:0] rin_q,     rin_d;
    logic        done_q,    done_d;
    logic        illegal_q, illegal_d;

    logic [15:0] alu_result;
    logic        alu_carry;
    logic        alu_writes;

    logic [2:0]  unused_instr;
    assign unused_instr = bus.INSTR[2:0];

    regfile_seq_alu u_alu (
        .opcode     (opcode_q),
        .a          (opa_q),
        .b          (opb_q),
        .result     (alu_result),
        .carry      (alu_carry),
        .writes_reg (alu_writes)
    );

`ifdef REGFILE_SEQUENCER_FLAGS_EN
    logic [2:0]  flags_q,   flags_d;
    logic        carry_q,   carry_d;
    logic        writes_q,  writes_d;
`else
    logic        unused_carry;
    assign unused_carry = alu_carry;
`endif

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        dst_d     = dst_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        ready_d   = ready_q;
        asel_d    = REG_ZERO;
        bsel_d    = REG_ZERO;
        dsel_d    = REG_ZERO;
        rin_d     = 16'd0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
`ifdef REGFILE_SEQUENCER_FLAGS_EN
        flags_d   = flags_q;
        carry_d   = carry_q;
        writes_d  = writes_q;
`endif
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (bus.INSTR_VALID && ready_q) begin
                    opcode_d = bus.INSTR[OPC_HI:OPC_LO];
                    dst_d    = bus.INSTR[DST_HI:DST_LO];
                    asel_d   = bus.INSTR[SRCA_HI:SRCA_LO];
                    bsel_d   = bus.INSTR[SRCB_HI:SRCB_LO];
                    ready_d  = 1'b0;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                // ABUS/BBUS are combinational from the registered selects.
                opa_d   = bus.ABUS;
                opb_d   = bus.BBUS;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // Outputs are registered, so the WRITE-cycle values are
                // loaded on the EXEC -> WRITE edge.
                rin_d     = alu_result;
                dsel_d    = alu_writes ? dst_q : REG_ZERO;
                done_d    = 1'b1;
                illegal_d = is_illegal(opcode_q);
`ifdef REGFILE_SEQUENCER_FLAGS_EN
                carry_d   = alu_carry;
                writes_d  = alu_writes;
`endif
                state_d   = ST_WRITE;
            end
            ST_WRITE: begin
`ifdef REGFILE_SEQUENCER_FLAGS_EN
                // Flags follow the result even when dst=0 discards it.
                if (writes_q) begin
                    flags_d = {rin_q[15], carry_q, (rin_q == 16'd0)};
                end
`endif
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            opcode_q  <= 4'd0;
            dst_q     <= 3'd0;
            opa_q     <= 16'd0;
            opb_q     <= 16'd0;
            ready_q   <= 1'b1;
            asel_q    <= REG_ZERO;
            bsel_q    <= REG_ZERO;
            dsel_q    <= REG_ZERO;
            rin_q     <= 16'd0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef REGFILE_SEQUENCER_FLAGS_EN
            flags_q   <= 3'd0;
            carry_q   <= 1'b0;
            writes_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            dst_q     <= dst_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            ready_q   <= ready_d;
            asel_q    <= asel_d;
            bsel_q    <= bsel_d;
            dsel_q    <= dsel_d;
            rin_q     <= rin_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
`ifdef REGFILE_SEQUENCER_FLAGS_EN
            flags_q   <= flags_d;
            carry_q   <= carry_d;
            writes_q  <= writes_d;
`endif
        end
    end

    assign bus.INSTR_READY = ready_q;
    assign bus.ASEL        = asel_q;
    assign bus.BSEL        = bsel_q;
    assign bus.DSEL        = dsel_q;
    assign bus.RIN         = rin_q;
    assign bus.DONE        = done_q;
    assign bus.ILLEGAL     = illegal_q;
`ifdef REGFILE_SEQUENCER_FLAGS_EN
    assign bus.FLAGS       = flags_q;
`endif
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer
// Directed bench for regfile_sequencer with a behavioural 8 x 16 register
// file attached (select 0 on ASEL returns din). Build with
// REGFILE_SEQUENCER_FLAGS_EN to also check FLAGS.
module tb_regfile_sequencer;
  import regfile_seq_pkg::*;

  logic        CLK;
  logic        RST;
  logic [15:0] din;
  state_e      state_dbg;
  int          tests;
  int          fails;
  int          done_cnt;
  logic        dsel5_seen;
  logic [15:0] rf [8];

  regfile_sequencer_if bus();

  regfile_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // register file model
  assign bus.ABUS = (bus.ASEL == 3'd0) ? din : rf[bus.ASEL];
  assign bus.BBUS = (bus.BSEL == 3'd0) ? din : rf[bus.BSEL];

  always @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'd0;
    end else if (bus.DSEL != 3'd0) begin
      rf[bus.DSEL] <= bus.RIN;
    end
    if (bus.DONE === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.DSEL === 3'd5) dsel5_seen <= 1'b1;
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] d,
                                      input logic [2:0] a, input logic [2:0] b);
    return {op, d, a, b, 3'b000};
  endfunction

  // driver: called at a negedge, returns at the negedge inside WRITE
  task automatic send(input logic [15:0] instr);
    int n;
    n = 0;
    while (bus.INSTR_READY !== 1'b1 && n < 8) begin
      @(negedge CLK);
      n++;
    end
    tests++;
    if (bus.INSTR_READY !== 1'b1) begin
      fails++;
      $display("FAIL send_ready_timeout got %b exp 1", bus.INSTR_READY);
    end
    bus.INSTR = instr;
    bus.INSTR_VALID = 1'b1;
    @(negedge CLK);
    bus.INSTR_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic load_reg(input logic [2:0] idx, input logic [15:0] val);
    din = val;
    send(enc(OP_MOV, idx, 3'd0, 3'd0));
    @(negedge CLK);
  endtask

  task automatic test_reset;
    RST = 1'b0;
    bus.INSTR_VALID = 1'b1;
    bus.INSTR = enc(OP_ADD, 3'd6, 3'd1, 3'd2);
    din = 16'h0000;
    repeat (3) @(negedge CLK);
    tests++;
    if (bus.INSTR_READY !== 1'b1) begin fails++; $display("FAIL rst_ready got %b exp 1", bus.INSTR_READY); end
    tests++;
    if (bus.DSEL !== 3'd0 || bus.RIN !== 16'd0) begin fails++; $display("FAIL rst_dsel_rin got %h/%h exp 0/0000", bus.DSEL, bus.RIN); end
    tests++;
    if (bus.DONE !== 1'b0 || bus.ILLEGAL !== 1'b0 || bus.ASEL !== 3'd0 || bus.BSEL !== 3'd0) begin
      fails++; $display("FAIL rst_pulses got done=%b ill=%b asel=%h bsel=%h exp 0", bus.DONE, bus.ILLEGAL, bus.ASEL, bus.BSEL);
    end
    tests++;
    if (state_dbg !== ST_IDLE) begin fails++; $display("FAIL rst_state got %0d exp 0", state_dbg); end
`ifdef REGFILE_SEQUENCER_FLAGS_EN
    tests++;
    if (bus.FLAGS !== 3'b000) begin fails++; $display("FAIL rst_flags got %b exp 000", bus.FLAGS); end
`endif
    // release with VALID still high: ADD r6 <- r1 + r2 (both 0) handshakes at once
    RST = 1'b1;
    @(negedge CLK);
    bus.INSTR_VALID = 1'b0;
    tests++;
    if (bus.INSTR_READY !== 1'b0 || bus.ASEL !== 3'd1 || bus.BSEL !== 3'd2) begin
      fails++; $display("FAIL rst_first_read got rdy=%b asel=%h bsel=%h exp 0/1/2", bus.INSTR_READY, bus.ASEL, bus.BSEL);
    end
    @(negedge CLK);
    @(negedge CLK);
    tests++;
    if (bus.DSEL !== 3'd6 || bus.DONE !== 1'b1 || bus.RIN !== 16'h0000) begin
      fails++; $display("FAIL rst_first_write got dsel=%h done=%b rin=%h exp 6/1/0000", bus.DSEL, bus.DONE, bus.RIN);
    end
    @(negedge CLK);
  endtask

  task automatic test_mov_add;
    int d0;
    d0 = done_cnt;
    din = 16'h1234;
    send(enc(OP_MOV, 3'd1, 3'd0, 3'd0));
    tests++;
    if (bus.DSEL !== 3'd1 || bus.RIN !== 16'h1234 || bus.DONE !== 1'b1) begin
      fails++; $display("FAIL mov_write got dsel=%h rin=%h done=%b exp 1/1234/1", bus.DSEL, bus.RIN, bus.DONE);
    end
    tests++;
    if (done_cnt !== d0) begin fails++; $display("FAIL mov_done_early got %0d exp %0d", done_cnt, d0); end
    @(negedge CLK);
    tests++;
    if (rf[1] !== 16'h1234) begin fails++; $display("FAIL mov_r1 got %h exp 1234", rf[1]); end
    send(enc(OP_ADD, 3'd2, 3'd1, 3'd1));
    tests++;
    if (bus.DSEL !== 3'd2 || bus.RIN !== 16'h2468 || bus.DONE !== 1'b1) begin
      fails++; $display("FAIL add_write got dsel=%h rin=%h done=%b exp 2/2468/1", bus.DSEL, bus.RIN, bus.DONE);
    end
    @(negedge CLK);
    tests++;
    if (rf[2] !== 16'h2468 || done_cnt !== d0 + 2) begin
      fails++; $display("FAIL add_r2 got %h done_cnt=%0d exp 2468 %0d", rf[2], done_cnt, d0 + 2);
    end
  endtask

  task automatic test_add_wrap;
    load_reg(3'd1, 16'hFFFF);
    load_reg(3'd2, 16'h0001);
    send(enc(OP_ADD, 3'd3, 3'd1, 3'd2));
    tests++;
    if (bus.DSEL !== 3'd3 || bus.RIN !== 16'h0000) begin
      fails++; $display("FAIL add_wrap got dsel=%h rin=%h exp 3/0000", bus.DSEL, bus.RIN);
    end
    @(negedge CLK);
    tests++;
    if (rf[3] !== 16'h0000) begin fails++; $display("FAIL add_wrap_r3 got %h exp 0000", rf[3]); end
`ifdef REGFILE_SEQUENCER_FLAGS_EN
    tests++;
    if (bus.FLAGS !== 3'b011) begin fails++; $display("FAIL add_wrap_flags got %b exp 011", bus.FLAGS); end
`endif
  endtask

  task automatic test_sub_illegal;
    // r1=FFFF, r2=0001 from test_add_wrap
    send(enc(OP_SUB, 3'd4, 3'd2, 3'd1));
    tests++;
    if (bus.DSEL !== 3'd4 || bus.RIN !== 16'h0002 || bus.ILLEGAL !== 1'b0) begin
      fails++; $display("FAIL sub got dsel=%h rin=%h ill=%b exp 4/0002/0", bus.DSEL, bus.RIN, bus.ILLEGAL);
    end
    @(negedge CLK);
    tests++;
    if (rf[4] !== 16'h0002) begin fails++; $display("FAIL sub_r4 got %h exp 0002", rf[4]); end
`ifdef REGFILE_SEQUENCER_FLAGS_EN
    tests++;
    if (bus.FLAGS !== 3'b010) begin fails++; $display("FAIL sub_flags got %b exp 010", bus.FLAGS); end
`endif
    send(enc(4'hC, 3'd5, 3'd1, 3'd2));
    tests++;
    if (bus.DSEL !== 3'd0 || bus.ILLEGAL !== 1'b1 || bus.DONE !== 1'b1) begin
      fails++; $display("FAIL illegal got dsel=%h ill=%b done=%b exp 0/1/1", bus.DSEL, bus.ILLEGAL, bus.DONE);
    end
    @(negedge CLK);
    tests++;
    if (bus.ILLEGAL !== 1'b0 || bus.DONE !== 1'b0) begin
      fails++; $display("FAIL illegal_pulse got ill=%b done=%b exp 0/0", bus.ILLEGAL, bus.DONE);
    end
`ifdef REGFILE_SEQUENCER_FLAGS_EN
    tests++;
    if (bus.FLAGS !== 3'b010) begin fails++; $display("FAIL illegal_flags got %b exp 010", bus.FLAGS); end
`endif
    // dst=0 discards the result but still completes
    send(enc(OP_ADD, 3'd0, 3'd2, 3'd2));
    tests++;
    if (bus.DSEL !== 3'd0 || bus.DONE !== 1'b1 || bus.RIN !== 16'h0002) begin
      fails++; $display("FAIL dst0 got dsel=%h done=%b rin=%h exp 0/1/0002", bus.DSEL, bus.DONE, bus.RIN);
    end
    @(negedge CLK);
  endtask

  task automatic test_ops;
    logic [3:0]  ops [8];
    logic [15:0] exp_v [8];
    logic [2:0]  exp_d [8];
    ops   = '{OP_MOV,  OP_AND,  OP_OR,   OP_XOR,  OP_NOT,  OP_SHL,  OP_SHR,  OP_NOP};
    exp_v = '{16'h8001, 16'h0001, 16'h80FF, 16'h80FE, 16'h7FFE, 16'h0002, 16'h4000, 16'h0000};
    exp_d = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd0};
    load_reg(3'd1, 16'h8001);
    load_reg(3'd2, 16'h00FF);
    for (int i = 0; i < 8; i++) begin
      send(enc(ops[i], 3'd7, 3'd1, 3'd2));
      tests++;
      if (bus.DSEL !== exp_d[i] || bus.RIN !== exp_v[i] || bus.DONE !== 1'b1) begin
        fails++; $display("FAIL op_%0d got dsel=%h rin=%h done=%b exp %h/%h/1", ops[i], bus.DSEL, bus.RIN, bus.DONE, exp_d[i], exp_v[i]);
      end
      @(negedge CLK);
`ifdef REGFILE_SEQUENCER_FLAGS_EN
      if (ops[i] == OP_SHL) begin
        tests++;
        if (bus.FLAGS !== 3'b010) begin fails++; $display("FAIL shl_flags got %b exp 010", bus.FLAGS); end
      end
`endif
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] prog [3];
    int hs [3];
    int k;
    int d0;
    prog = '{enc(OP_MOV, 3'd1, 3'd0, 3'd0), enc(OP_ADD, 3'd2, 3'd1, 3'd1), enc(OP_ADD, 3'd3, 3'd2, 3'd1)};
    hs = '{-1, -1, -1};
    k = 0;
    d0 = done_cnt;
    din = 16'h0A0A;
    bus.INSTR_VALID = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (bus.INSTR_READY === 1'b1) begin
        if (k < 3) begin
          bus.INSTR = prog[k];
          hs[k] = cyc;
          k++;
        end else begin
          bus.INSTR_VALID = 1'b0;
        end
      end else begin
        // garbage while busy must be ignored
        bus.INSTR = 16'(32'hF000 | $urandom_range(0, 16'h0FFF));
      end
      @(negedge CLK);
    end
    bus.INSTR_VALID = 1'b0;
    tests++;
    if (hs[1] - hs[0] !== 4 || hs[2] - hs[1] !== 4) begin
      fails++; $display("FAIL b2b_spacing got %0d,%0d,%0d exp gaps of 4", hs[0], hs[1], hs[2]);
    end
    tests++;
    if (done_cnt !== d0 + 3) begin fails++; $display("FAIL b2b_done_count got %0d exp %0d", done_cnt - d0, 3); end
    tests++;
    if (rf[1] !== 16'h0A0A || rf[2] !== 16'h1414 || rf[3] !== 16'h1E1E) begin
      fails++; $display("FAIL b2b_regs got %h %h %h exp 0a0a 1414 1e1e", rf[1], rf[2], rf[3]);
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    load_reg(3'd5, 16'hBEEF);
    load_reg(3'd1, 16'h0003);
    load_reg(3'd2, 16'h0004);
    dsel5_seen = 1'b0;
    d0 = done_cnt;
    bus.INSTR = enc(OP_ADD, 3'd5, 3'd1, 3'd2);
    bus.INSTR_VALID = 1'b1;
    @(negedge CLK);              // READ
    bus.INSTR_VALID = 1'b0;
    @(negedge CLK);              // EXEC
    tests++;
    if (state_dbg !== ST_EXEC) begin fails++; $display("FAIL mid_state got %0d exp 2", state_dbg); end
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    tests++;
    if (dsel5_seen !== 1'b0 || done_cnt !== d0) begin
      fails++; $display("FAIL mid_abort got dsel5=%b done=%0d exp 0 %0d", dsel5_seen, done_cnt - d0, 0);
    end
    tests++;
    if (bus.INSTR_READY !== 1'b1 || state_dbg !== ST_IDLE) begin
      fails++; $display("FAIL mid_idle got rdy=%b st=%0d exp 1/0", bus.INSTR_READY, state_dbg);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    done_cnt = 0;
    dsel5_seen = 1'b0;
    din = 16'h0000;
    RST = 1'b0;
    bus.INSTR = 16'h0000;
    bus.INSTR_VALID = 1'b0;
    @(negedge CLK);
    test_reset();
    test_mov_add();
    test_add_wrap();
    test_sub_illegal();
    test_ops();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
